// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the pixel-count type used by the
// sync generator and block_controller.
package vga_pkg;

    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned CLK_DIV  = 4;

    typedef logic [9:0] pix_cnt_t;

    function automatic int unsigned vis_start(input int unsigned sync_w, input int unsigned bp_w);
        return sync_w + bp_w;
    endfunction

    function automatic int unsigned vis_end(input int unsigned sync_w, input int unsigned bp_w,
                                            input int unsigned active_w);
        return sync_w + bp_w + active_w - 1;
    endfunction

    localparam int unsigned H_VIS_START = vis_start(H_SYNC, H_BP);
    localparam int unsigned H_VIS_END   = vis_end(H_SYNC, H_BP, H_ACTIVE);
    localparam int unsigned V_VIS_START = vis_start(V_SYNC, V_BP);
    localparam int unsigned V_VIS_END   = vis_end(V_SYNC, V_BP, V_ACTIVE);

endpackage

// File: rtl/vga_clk_div.sv
// Pixel-enable divider: one-clk pulse every CLK_DIV board clocks, first pulse
// CLK_DIV clocks after reset release. Used only when VGA_CLKDIV_EN is defined.
module vga_clk_div
    import vga_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_en
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] r_div;
    logic       r_pix_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= 2'd0;
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= (r_div == DIV_LAST);
            r_div    <= (r_div == DIV_LAST) ? 2'd0 : r_div + 2'd1;
        end
    end

    assign o_pix_en = r_pix_en;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator. Define VGA_CLKDIV_EN to divide the 100 MHz
// clock down to a 25 MHz pixel rate; otherwise pixels advance every clk.
module vga_sync_gen
    import vga_pkg::pix_cnt_t, vga_pkg::vis_start, vga_pkg::vis_end;
#(
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL
) (
    input  logic     clk,
    input  logic     rst,
    output logic     pix_en,
    output pix_cnt_t hCount,
    output pix_cnt_t vCount,
    output logic     hSync,
    output logic     vSync,
    output logic     bright,
    output logic     frame_start
);

    localparam pix_cnt_t H_LAST     = pix_cnt_t'(H_TOTAL - 1);
    localparam pix_cnt_t V_LAST     = pix_cnt_t'(V_TOTAL - 1);
    localparam pix_cnt_t H_SYNC_END = pix_cnt_t'(H_SYNC);
    localparam pix_cnt_t V_SYNC_END = pix_cnt_t'(V_SYNC);
    localparam pix_cnt_t H_VS       = pix_cnt_t'(vis_start(H_SYNC, H_BP));
    localparam pix_cnt_t H_VE       = pix_cnt_t'(vis_end(H_SYNC, H_BP, H_ACTIVE));
    localparam pix_cnt_t V_VS       = pix_cnt_t'(vis_start(V_SYNC, V_BP));
    localparam pix_cnt_t V_VE       = pix_cnt_t'(vis_end(V_SYNC, V_BP, V_ACTIVE));

    logic     w_pix_en;
    logic     w_h_wrap;
    pix_cnt_t w_h_next;
    pix_cnt_t w_v_next;

    pix_cnt_t r_h_cnt;
    pix_cnt_t r_v_cnt;
    logic     r_hsync;
    logic     r_vsync;
    logic     r_bright;
    logic     r_frame_start;

`ifdef VGA_CLKDIV_EN
    vga_clk_div u_clk_div (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .o_pix_en (w_pix_en)
    );
`else
    // Enable is held low only while in reset, then stays high.
    logic r_pix_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pix_on <= 1'b0;
        else      r_pix_on <= 1'b1;
    end

    assign w_pix_en = r_pix_on;
`endif

    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h_cnt + 10'd1;
        w_v_next = r_v_cnt;
        if (w_h_wrap) w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end

    // Decodes use the next counts so they line up with the registered counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_bright      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en && w_h_wrap && (r_v_cnt == V_LAST);
            if (w_pix_en) begin
                r_h_cnt  <= w_h_next;
                r_v_cnt  <= w_v_next;
                r_hsync  <= (w_h_next >= H_SYNC_END);
                r_vsync  <= (w_v_next >= V_SYNC_END);
                r_bright <= (w_h_next >= H_VS) && (w_h_next <= H_VE) &&
                            (w_v_next >= V_VS) && (w_v_next <= V_VE);
            end
        end
    end

    assign pix_en      = w_pix_en;
    assign hCount      = r_h_cnt;
    assign vCount      = r_v_cnt;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign bright      = r_bright;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shortened vertical frame; horizontal timing is
// the real 800-pixel line.
module tb_vga_sync_gen;

    localparam int H_TOTAL  = 800;
    localparam int H_SYNC   = 96;
    localparam int H_VS     = 144;
    localparam int H_VE     = 783;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int V_ACTIVE = 4;
    localparam int V_TOTAL  = 10;
    localparam int V_VS     = 5;
    localparam int V_VE     = 8;
    localparam int FRAME_PX = H_TOTAL * V_TOTAL;
`ifdef VGA_CLKDIV_EN
    localparam int DIV      = 4;
    localparam int POST_PX  = 1000;
`else
    localparam int DIV      = 1;
    localparam int POST_PX  = FRAME_PX + 200;
`endif
    localparam int POST_FS  = (POST_PX > FRAME_PX) ? 1 : 0;
    localparam int W        = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_start;

    vga_sync_gen #(
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .hSync       (hSync),
        .vSync       (vSync),
        .bright      (bright),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;
    int phase  = 0;
    int hs_low = 0;
    int vs_low = 0;
    int fs_cnt = 0;
    bit abort  = 1'b0;
    bit wrap_done = 1'b0;
    logic [W-1:0] exp_q[$];

    int pt_h[6] = '{143, 144, 783, 784, 144, 144};
    int pt_v[6] = '{5, 5, 8, 8, 4, 9};
    int pt_b[6] = '{0, 1, 1, 0, 0, 0};
    bit pt_done[6] = '{0, 0, 0, 0, 0, 0};

    // Pixel advances completed after kk clock edges since reset release.
    function automatic int advances(input int kk);
        return (kk >= 1) ? (kk - 1) / DIV : 0;
    endfunction

    function automatic logic [W-1:0] model(input int kk);
        int a, p, h, v;
        logic pe, fs;
        a  = advances(kk);
        p  = a % FRAME_PX;
        h  = p % H_TOTAL;
        v  = p / H_TOTAL;
        pe = (kk >= DIV) && (kk % DIV == 0);
        fs = (kk >= 1) && (a != advances(kk - 1)) && (p == 0);
        return {pe, 10'(h), 10'(v), (h >= H_SYNC), (v >= V_SYNC),
                (h >= H_VS && h <= H_VE && v >= V_VS && v <= V_VE), fs};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {pix_en, hCount, vCount, hSync, vSync, bright, frame_start};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs_vec(), e);
        end
    endtask

    task automatic run(input int n);
        logic [W-1:0] e;
        logic [9:0]   h, v;
        bit           adv;
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            @(posedge clk);
            k++;
            exp_q.push_back(model(k));
            @(negedge clk);
            e   = exp_q[0];
            h   = e[23:14];
            v   = e[13:4];
            adv = (advances(k) != advances(k - 1));
            sb_check("cycle");
            if (k == DIV) check("first_pix_en", W'(pix_en), W'(1));
            if (DIV > 1 && k == DIV - 1) check("pix_en_early", W'(pix_en), W'(0));
            if (phase == 1 && adv && v == 10'd1 && hSync == 1'b0) hs_low++;
            if (phase == 1 && adv && h == 10'd0 && vSync == 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_cnt++;
            if (phase == 1 && adv && h == 10'd0 && v == 10'd1 && !wrap_done) begin
                check("line_wrap", W'({hCount, vCount}), W'({10'd0, 10'd1}));
                wrap_done = 1'b1;
            end
            for (int j = 0; j < 6; j++) begin
                if (!pt_done[j] && int'(h) == pt_h[j] && int'(v) == pt_v[j]) begin
                    check("bright_pt", W'(bright), W'(pt_b[j]));
                    pt_done[j] = 1'b1;
                end
            end
            if (n_fail > 30) abort = 1'b1;
        end
    endtask

    initial begin
        int target;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_q.push_back(model(0));
            sb_check("reset_hold");
        end

        rst   = 1'b1;
        k     = 0;
        phase = 1;
        run((FRAME_PX + 200) * DIV);
        check("hsync_low_px", W'(hs_low), W'(96));
        check("vsync_low_lines", W'(vs_low), W'(2));
        check("frame_start_cnt", W'(fs_cnt), W'(1));

        phase  = 2;
        target = FRAME_PX + 6 * H_TOTAL + 400;
        while (!abort && advances(k) < target) run(1);
        check("pre_reset_pos", W'({hCount, vCount}), W'({10'd400, 10'd6}));

        rst = 1'b0;
        #1;
        exp_q.push_back(model(0));
        sb_check("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_q.push_back(model(0));
            sb_check("reset_mid_hold");
        end

        rst    = 1'b1;
        k      = 0;
        fs_cnt = 0;
        phase  = 3;
        run(POST_PX * DIV);
        check("fs_after_restart", W'(fs_cnt), W'(POST_FS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
